// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and constants for the data-memory SRAM path
package arm_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LO,
      ST_HI,
      ST_WAIT,
      ST_DONE
   } mem_state_e;

   localparam int          SRAM_AW           = 18;
   localparam int          SRAM_DW           = 16;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - sequences 32-bit loads/stores as two half-word cycles on a 16-bit async SRAM
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          WAIT_CYCLES = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   mem_state_e         state_q;
   logic [3:0]         cnt_q;
   logic               op_rd_q;
   logic [16:0]        word_q;
   logic [31:0]        wdata_q;
   logic [31:0]        read_data_q;
   logic [SRAM_AW-1:0] sram_addr_q;
   logic [SRAM_DW-1:0] dq_out_q;
   logic               dq_oe_q;
   logic               we_n_q;
   logic               oe_n_q;

   logic               req_d;
   logic [31:0]        offset_d;
   logic [16:0]        word_d;
   logic               unused_offset;

   // Addresses below BASE_ADDR wrap modulo 2^32 into the top of the SRAM.
   assign offset_d      = address - BASE_ADDR;
   assign word_d        = offset_d[18:2];
   assign unused_offset = ^{offset_d[31:19], offset_d[1:0]};
   assign req_d         = rd_en | wr_en;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         op_rd_q     <= 1'b0;
         word_q      <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_d) begin
                  // A simultaneous load and store resolves to the load.
                  op_rd_q     <= rd_en;
                  word_q      <= word_d;
                  wdata_q     <= write_data;
                  sram_addr_q <= {word_d, 1'b0};
                  if (rd_en) begin
                     oe_n_q  <= 1'b0;
                     we_n_q  <= 1'b1;
                     dq_oe_q <= 1'b0;
                  end else begin
                     oe_n_q   <= 1'b1;
                     we_n_q   <= 1'b0;
                     dq_oe_q  <= 1'b1;
                     dq_out_q <= write_data[15:0];
                  end
                  state_q <= ST_LO;
               end
            end
            ST_LO: begin
               if (op_rd_q) begin
                  read_data_q[15:0] <= sram_dq_in;
               end else begin
                  dq_out_q <= wdata_q[31:16];
               end
               sram_addr_q <= {word_q, 1'b1};
               state_q     <= ST_HI;
            end
            ST_HI: begin
               if (op_rd_q) begin
                  read_data_q[31:16] <= sram_dq_in;
               end
               we_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
               dq_oe_q <= 1'b0;
               cnt_q   <= WAIT_LOAD;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      ready = 1'b0;
      if (state_q == ST_IDLE) begin
         ready = ~req_d;
      end else if (state_q == ST_DONE) begin
         ready = 1'b1;
      end
   end

   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_we_n   = we_n_q;
   assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller against a word-level memory model
module tb_sram_controller;

   localparam logic [31:0] BASE = 32'd1024;
   localparam int          WAIT = 3;
   localparam int          LAT  = 3 + WAIT;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
   logic        sram_oe_n;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] mem [0:262143];
   logic [31:0] ref_word [int];
   logic [31:0] last_read;

   sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in),
      .sram_we_n   (sram_we_n),
      .sram_oe_n   (sram_oe_n)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM model: reads while OE# is low, writes while WE# is low.
   assign sram_dq_in = !sram_oe_n ? mem[sram_addr] : 16'h0000;
   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
   end

   function automatic int word_idx(input logic [31:0] a);
      logic [31:0] w;
      w = (a - BASE) >> 2;
      return int'(w[16:0]);
   endfunction

   function automatic logic [31:0] ref_rd(input int w);
      if (ref_word.exists(w)) return ref_word[w];
      return 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      rd_en = 1'b0;
      wr_en = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_ready", 32'(ready), 32'd1);
         chk("idle_we_n", 32'(sram_we_n), 32'd1);
         chk("idle_oe_n", 32'(sram_oe_n), 32'd1);
         chk("idle_dq_oe", 32'(sram_dq_oe), 32'd0);
         @(posedge clk);
         #1;
      end
   endtask

   // Starts at #1 after the edge opening cycle 0; returns at the same point of cycle LAT+1.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] alt_addr,
                         input logic [31:0] alt_wdata);
      int          w;
      logic        is_rd;
      logic [17:0] ha;
      w     = word_idx(addr);
      is_rd = rd;
      rd_en      = rd;
      wr_en      = wr;
      address    = addr;
      write_data = wdata;
      for (int c = 0; c <= LAT; c++) begin
         if (c == 2) begin
            address    = alt_addr;
            write_data = alt_wdata;
         end
         @(negedge clk);
         chk($sformatf("ready_c%0d", c), 32'(ready), 32'(c == LAT));
         if (c == 1 || c == 2) begin
            ha = {w[16:0], 1'(c == 2)};
            chk($sformatf("addr_c%0d", c), 32'(sram_addr), 32'(ha));
            chk($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'(is_rd));
            chk($sformatf("oe_n_c%0d", c), 32'(sram_oe_n), 32'(!is_rd));
            chk($sformatf("dq_oe_c%0d", c), 32'(sram_dq_oe), 32'(!is_rd));
            if (!is_rd)
               chk($sformatf("dq_out_c%0d", c), 32'(sram_dq_out),
                   32'(c == 1 ? wdata[15:0] : wdata[31:16]));
         end else begin
            chk($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'd1);
            chk($sformatf("oe_n_c%0d", c), 32'(sram_oe_n), 32'd1);
            chk($sformatf("dq_oe_c%0d", c), 32'(sram_dq_oe), 32'd0);
         end
         if (c >= 3)
            chk("addr_hold", 32'(sram_addr), 32'({w[16:0], 1'b1}));
         if (c == 1)
            chk("rdata_held", read_data, last_read);
         if (c == LAT)
            chk(is_rd ? "rdata_load" : "rdata_keep", read_data, is_rd ? ref_rd(w) : last_read);
         @(posedge clk);
         #1;
      end
      if (is_rd) last_read = ref_rd(w);
      else       ref_word[w] = wdata;
   endtask

   initial begin
      int          op;
      logic [31:0] a;
      for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
      mem[2] = 16'h1234;
      mem[3] = 16'hABCD;
      ref_word[1] = 32'hABCD1234;
      last_read   = 32'h0;

      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_read_data", read_data, 32'h0);
      chk("rst_sram_addr", 32'(sram_addr), 32'h0);
      chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;

      idle(5);
      access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'd1024, 32'hDEADBEEF);
      access(1'b1, 1'b0, 32'd1028, 32'h0, 32'd1028, 32'h0);
      chk("read_const", read_data, 32'hABCD1234);
      idle(1);
      access(1'b0, 1'b1, 32'd0, 32'h0BADF00D, 32'd0, 32'h0BADF00D);
      access(1'b1, 1'b1, 32'd1024, 32'h11111111, 32'd2048, 32'h22222222);
      chk("both_const", read_data, 32'hDEADBEEF);

      // Reset in the LO cycle of a store: low half lands, high half never does.
      rd_en = 1'b0; wr_en = 1'b1; address = BASE + 32'd8; write_data = 32'h55AA66BB;
      @(negedge clk);
      chk("rstmid_ready_c0", 32'(ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_we_n_c1", 32'(sram_we_n), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; wr_en = 1'b0;
      @(negedge clk);
      chk("rstmid_we_n", 32'(sram_we_n), 32'd1);
      chk("rstmid_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("rstmid_read_data", read_data, 32'h0);
      chk("rstmid_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      ref_word[2] = {ref_rd(2) & 32'hFFFF0000} | 32'h000066BB;
      last_read   = 32'h0;
      access(1'b1, 1'b0, BASE + 32'd9, 32'h0, BASE + 32'd9, 32'h0);

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         if ($urandom_range(0, 7) == 0)
            a = BASE - 32'(($urandom_range(1, 4)) << 2) + 32'($urandom_range(0, 3));
         else
            a = BASE + 32'(($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
         access(op != 1, op != 0, a, $urandom, $urandom, $urandom);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
      end
      idle(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
